// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t   : fetch FSM state (IDLE, WAIT, DROP)
//   INSTR_BYTES     : PC increment per fetched word
//   ADDR_ALIGN_MASK : clears bits [1:0] to force word alignment
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // free to issue a request
        WAIT = 2'd1,   // one request granted, response pending
        DROP = 2'd2    // response pending but already stale (redirected)
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES     = 32'd4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_obuf.sv
// ifetch_obuf: single-entry valid/ready buffer holding one instruction and
// its PC for the decoder.
//   clock, reset          : clock, synchronous active-high reset
//   load, load_data/pc    : capture a new entry (sets out_valid)
//   flush                 : drop the entry (clears out_valid)
//   out_valid/data/pc     : buffered entry
//   out_ready             : consumer accepts the entry this cycle
module ifetch_obuf (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_pc
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        // Flush wins; otherwise a load reloads even while the old entry
        // transfers on the same edge. Data is held while stalled.
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            pc_d    = load_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Holds the PC, issues word-aligned requests
// over req/gnt/rvalid with at most one outstanding, and hands fetched words
// with their PC to the decoder through a single-entry output buffer.
//   clock, reset                 : clock, synchronous active-high reset
//   imem_req/addr, imem_gnt      : request channel to instruction memory
//   imem_rvalid/rdata            : in-order response channel (never stalled)
//   instr_valid/instr/instr_pc   : output to decoder, instr_ready accepts
//   redirect/redirect_pc         : load a new PC and flush in-flight work
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         buf_load;
    logic         buf_flush;

    always_comb begin
        // Only request when the buffer is empty or draining, so a response
        // always finds room and rvalid never needs back-pressure.
        imem_req  = (state_q == IDLE) && (!instr_valid || instr_ready)
                    && !redirect && !reset;
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;

        if (redirect) begin
            pc_d      = redirect_pc & ADDR_ALIGN_MASK;
            buf_flush = 1'b1;
            // A response arriving this cycle closes out the outstanding
            // request (its data is dropped); otherwise it is still owed.
            case (state_q)
                IDLE:    state_d = IDLE;
                WAIT:    state_d = imem_rvalid ? IDLE : DROP;
                DROP:    state_d = imem_rvalid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (imem_req && imem_gnt) begin
                        pc_d    = pc_q + INSTR_BYTES;  // wraps mod 2^32
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        buf_load = 1'b1;
                        state_d  = IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & ADDR_ALIGN_MASK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    // pc_q already points past the word in flight, so its address is pc-4.
    ifetch_obuf u_obuf (
        .clock     (clock),
        .reset     (reset),
        .load      (buf_load),
        .flush     (buf_flush),
        .load_data (imem_rdata),
        .load_pc   (pc_q - INSTR_BYTES),
        .out_ready (instr_ready),
        .out_valid (instr_valid),
        .out_data  (instr),
        .out_pc    (instr_pc)
    );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch. A table of per-cycle vectors covers
// the steady fetch stream and back-pressure; hand-written sequences cover
// redirects, grant stalls, reset mid-fetch and PC wrap (second instance).
module tb_ifetch;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Second instance for PC wrap, memory driven by hand.
    logic        reset1;
    logic        req1;
    logic [31:0] addr1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        valid1;
    logic [31:0] instr1;
    logic [31:0] pc1;
    logic        ready1;

    int total = 0;
    int bad   = 0;

    // Memory model knobs
    logic        gnt_en;
    int          rsp_delay;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_cnt = 0;

    always #5 clock = ~clock;

    ifetch #(.RESET_PC(32'h0000_0100)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock       (clock),
        .reset       (reset1),
        .imem_req    (req1),
        .imem_addr   (addr1),
        .imem_gnt    (gnt1),
        .imem_rvalid (rvalid1),
        .imem_rdata  (rdata1),
        .instr_valid (valid1),
        .instr       (instr1),
        .instr_pc    (pc1),
        .instr_ready (ready1),
        .redirect    (1'b0),
        .redirect_pc (32'd0)
    );

    assign imem_gnt = gnt_en;

    // Memory: response rsp_delay cycles after grant, data = addr ^ key.
    // Pending response is cancelled by reset.
    always @(posedge clock) begin
        if (reset) begin
            pend        <= 1'b0;
            pend_cnt    <= 0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (pend_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= pend_addr ^ XOR_KEY;
                    pend        <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (imem_req && imem_gnt) begin
                if (rsp_delay <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= imem_addr ^ XOR_KEY;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    pend_cnt  <= rsp_delay - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ready, req, addr, valid, instr, pc (instr/pc checked only if valid)
        vecs[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'h104, 1'b1, 32'hA5A5_A4A5, 32'h100};
        vecs[3]  = '{1'b1, 1'b0, 32'h108, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'hA5A5_A4A1, 32'h104};
        vecs[5]  = '{1'b1, 1'b0, 32'h10C, 1'b0, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[7]  = '{1'b0, 1'b0, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[8]  = '{1'b0, 1'b0, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[9]  = '{1'b0, 1'b0, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[10] = '{1'b0, 1'b0, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[11] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'hA5A5_A4AD, 32'h108};
        vecs[12] = '{1'b1, 1'b0, 32'h110, 1'b0, 32'h0,         32'h0};

        reset       = 1'b1;
        reset1      = 1'b1;
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        rsp_delay   = 1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        gnt1        = 1'b1;
        rvalid1     = 1'b0;
        rdata1      = 32'd0;
        ready1      = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'h100);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_pc",    instr_pc,             32'd0);
        chk("rst_req1",  {31'd0, req1},        32'd0);
        $display("txn reset state checked");

        // PC wrap on the second instance
        step(); reset1 = 1'b0;
        @(negedge clock);
        chk("wrap_req0",  {31'd0, req1}, 32'd1);
        chk("wrap_addr0", addr1,         32'hFFFF_FFFC);
        step(); rvalid1 = 1'b1; rdata1 = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("wrap_req_wait", {31'd0, req1}, 32'd0);
        chk("wrap_addr1",    addr1,         32'h0000_0000);
        step(); rvalid1 = 1'b0;
        @(negedge clock);
        chk("wrap_valid", {31'd0, valid1}, 32'd1);
        chk("wrap_instr", instr1,          32'hDEAD_BEEF);
        chk("wrap_pc",    pc1,             32'hFFFF_FFFC);
        chk("wrap_req2",  {31'd0, req1},   32'd1);
        chk("wrap_addr2", addr1,           32'h0000_0000);
        step(); gnt1 = 1'b0;
        @(negedge clock);
        chk("wrap_drain", {31'd0, valid1}, 32'd0);
        $display("txn pc wrap sequence");

        // Steady stream and back-pressure
        step(); reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            instr_ready = vecs[i].ready;
            @(negedge clock);
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].valid});
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_instr", i), instr,    vecs[i].instr);
                chk($sformatf("v%0d_pc", i),    instr_pc, vecs[i].pc);
            end
            $display("txn vec %0d ready=%0b req=%0b addr=%h valid=%0b instr=%h pc=%h",
                     i, instr_ready, imem_req, imem_addr, instr_valid, instr, instr_pc);
            step();
        end

        // Redirect while WAIT, response delayed
        rsp_delay = 3;
        @(negedge clock);
        chk("c13_instr", instr,             32'hA5A5_A4A9);
        chk("c13_pc",    instr_pc,          32'h10C);
        chk("c13_req",   {31'd0, imem_req}, 32'd1);
        step(); redirect = 1'b1; redirect_pc = 32'h2003;
        @(negedge clock);
        chk("rdw_req", {31'd0, imem_req}, 32'd0);
        step(); redirect = 1'b0; rsp_delay = 1;
        @(negedge clock);
        chk("drop_req",   {31'd0, imem_req},    32'd0);
        chk("drop_addr",  imem_addr,            32'h2000);
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        step();
        @(negedge clock);
        chk("drop_rvalid", {31'd0, imem_rvalid}, 32'd1);
        chk("drop_req2",   {31'd0, imem_req},    32'd0);
        step();
        @(negedge clock);
        chk("drop_stale", {31'd0, instr_valid}, 32'd0);
        chk("drop_req3",  {31'd0, imem_req},    32'd1);
        chk("drop_addr3", imem_addr,            32'h2000);
        step(); step();
        @(negedge clock);
        chk("rd_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_instr", instr,                32'hA5A5_85A5);
        chk("rd_pc",    instr_pc,             32'h2000);
        $display("txn redirect in WAIT to %h", 32'h2003);

        // Redirect coincident with rvalid
        step(); redirect = 1'b1; redirect_pc = 32'h3000;
        @(negedge clock);
        chk("rr_rvalid", {31'd0, imem_rvalid}, 32'd1);
        step(); redirect = 1'b0;
        @(negedge clock);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rr_req",   {31'd0, imem_req},    32'd1);
        chk("rr_addr",  imem_addr,            32'h3000);
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h4000;
        @(negedge clock);
        chk("rt_valid", {31'd0, instr_valid}, 32'd1);
        chk("rt_instr", instr,                32'hA5A5_95A5);
        chk("rt_pc",    instr_pc,             32'h3000);
        $display("txn redirect with rvalid, then with transfer");

        // Redirect during transfer, then back-to-back redirects
        step(); redirect_pc = 32'h5000;
        @(negedge clock);
        chk("rt_clear", {31'd0, instr_valid}, 32'd0);
        chk("bb_addr0", imem_addr,            32'h4000);
        step(); redirect_pc = 32'h6000;
        @(negedge clock);
        chk("bb_addr1", imem_addr, 32'h5000);
        step(); redirect = 1'b0; gnt_en = 1'b0;
        @(negedge clock);
        chk("bb_req",  {31'd0, imem_req}, 32'd1);
        chk("bb_addr", imem_addr,         32'h6000);
        $display("txn back-to-back redirects");

        // Grant withheld, then reset mid-WAIT
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clock);
            chk($sformatf("gh%0d_req", i),  {31'd0, imem_req}, 32'd1);
            chk($sformatf("gh%0d_addr", i), imem_addr,         32'h6000);
        end
        step(); gnt_en = 1'b1; rsp_delay = 5;
        @(negedge clock);
        chk("gnt_addr", imem_addr, 32'h6000);
        step();
        @(negedge clock);
        chk("gw_req",  {31'd0, imem_req}, 32'd0);
        chk("gw_addr", imem_addr,         32'h6004);
        step(); reset = 1'b1;
        @(negedge clock);
        chk("mr_req0", {31'd0, imem_req}, 32'd0);
        step();
        @(negedge clock);
        chk("mr_req",   {31'd0, imem_req},    32'd0);
        chk("mr_addr",  imem_addr,            32'h100);
        chk("mr_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_instr", instr,                32'd0);
        chk("mr_pc",    instr_pc,             32'd0);
        step(); reset = 1'b0;
        @(negedge clock);
        chk("post_req",    {31'd0, imem_req},    32'd1);
        chk("post_addr",   imem_addr,            32'h100);
        chk("post_rvalid", {31'd0, imem_rvalid}, 32'd0);
        step();
        @(negedge clock);
        chk("post_addr2", imem_addr, 32'h104);
        $display("txn grant stall and reset mid-WAIT");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
